// File: rtl/div_ctrl.sv
// Multi-cycle radix-2 restoring divider for MIPS DIV/DIVU in the EX stage.
// Stalls the front of the pipeline while iterating and presents HI/LO results in DONE.
module div_ctrl #(
    parameter int WIDTH = 32,
    parameter int CNT_W = 6
) (
    input  logic             clk,
    input  logic             resetn,
    input  logic             div_en,
    input  logic             div_signed,
    input  logic [WIDTH-1:0] src_a,
    input  logic [WIDTH-1:0] src_b,
    input  logic             flush,
    input  logic             pipe_hold,
    output logic             div_stall,
    output logic             res_valid,
    output logic [WIDTH-1:0] quotient,
    output logic [WIDTH-1:0] remainder
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [WIDTH-1:0] rem_q, rem_d;
    logic [WIDTH-1:0] dvd_q, dvd_d;
    logic [WIDTH-1:0] dvs_q, dvs_d;
    logic [WIDTH-1:0] quo_q, quo_d;
    logic [WIDTH-1:0] rmd_q, rmd_d;
    logic             neg_quo_q, neg_quo_d;
    logic             neg_rem_q, neg_rem_d;

    logic             start;
    logic             last_iter;
    logic [WIDTH:0]   shifted;
    logic [WIDTH:0]   trial;

    assign start     = div_en && !flush;
    assign last_iter = (cnt_q == CNT_W'(WIDTH - 1));

    // NOTE: state is updated only with non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state_q   <= IDLE;
            cnt_q     <= '0;
            rem_q     <= '0;
            dvd_q     <= '0;
            dvs_q     <= '0;
            quo_q     <= '0;
            rmd_q     <= '0;
            neg_quo_q <= 1'b0;
            neg_rem_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            rem_q     <= rem_d;
            dvd_q     <= dvd_d;
            dvs_q     <= dvs_d;
            quo_q     <= quo_d;
            rmd_q     <= rmd_d;
            neg_quo_q <= neg_quo_d;
            neg_rem_q <= neg_rem_d;
        end
    end

    // NOTE: every comb output gets a default first so no path leaves it unassigned (no latches).
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (start) state_d = CALC;
            CALC: begin
                if (flush)          state_d = IDLE;
                else if (last_iter) state_d = DONE;
            end
            DONE:    if (flush || !pipe_hold) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // The dividend register shifts out its MSB each cycle and fills with quotient bits.
    always_comb begin
        cnt_d     = cnt_q;
        rem_d     = rem_q;
        dvd_d     = dvd_q;
        dvs_d     = dvs_q;
        quo_d     = quo_q;
        rmd_d     = rmd_q;
        neg_quo_d = neg_quo_q;
        neg_rem_d = neg_rem_q;
        shifted   = {rem_q, dvd_q[WIDTH-1]};
        trial     = shifted - {1'b0, dvs_q};

        case (state_q)
            IDLE: begin
                if (start) begin
                    dvd_d     = (div_signed && src_a[WIDTH-1]) ? -src_a : src_a;
                    dvs_d     = (div_signed && src_b[WIDTH-1]) ? -src_b : src_b;
                    neg_quo_d = div_signed && (src_a[WIDTH-1] ^ src_b[WIDTH-1]);
                    neg_rem_d = div_signed && src_a[WIDTH-1];
                    rem_d     = '0;
                    cnt_d     = '0;
                end
            end
            CALC: begin
                if (!flush) begin
                    dvd_d = {dvd_q[WIDTH-2:0], !trial[WIDTH]};
                    rem_d = trial[WIDTH] ? shifted[WIDTH-1:0] : trial[WIDTH-1:0];
                    cnt_d = cnt_q + CNT_W'(1);
                    if (last_iter) begin
                        quo_d = neg_quo_q ? -dvd_d : dvd_d;
                        rmd_d = neg_rem_q ? -rem_d : rem_d;
                    end
                end
            end
            default: ;
        endcase
    end

    // Stall is gated by resetn so it reads 0 while reset is asserted, whatever the inputs.
    always_comb begin
        div_stall = resetn && (((state_q == IDLE) && start) || ((state_q == CALC) && !flush));
        res_valid = (state_q == DONE);
        quotient  = quo_q;
        remainder = rmd_q;
    end

endmodule

// File: tb/tb_div_ctrl.sv
// Self-checking bench for div_ctrl: directed MIPS DIV/DIVU cases plus randomized
// divides compared against an arithmetic reference model.
module tb_div_ctrl;

    logic        clk;
    logic        resetn;
    logic        div_en;
    logic        div_signed;
    logic [31:0] src_a;
    logic [31:0] src_b;
    logic        flush;
    logic        pipe_hold;
    logic        div_stall;
    logic        res_valid;
    logic [31:0] quotient;
    logic [31:0] remainder;

    int errors;
    int checks;

    div_ctrl #(.WIDTH(32), .CNT_W(6)) dut (
        .clk        (clk),
        .resetn     (resetn),
        .div_en     (div_en),
        .div_signed (div_signed),
        .src_a      (src_a),
        .src_b      (src_b),
        .flush      (flush),
        .pipe_hold  (pipe_hold),
        .div_stall  (div_stall),
        .res_valid  (res_valid),
        .quotient   (quotient),
        .remainder  (remainder)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            errors++;
            $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Reference: divide magnitudes, divide-by-zero gives all-ones / dividend, then apply signs.
    task automatic model(input logic [31:0] a, input logic [31:0] b, input logic sgn,
                         output logic [31:0] q, output logic [31:0] r);
        logic        neg_a, neg_b;
        logic [31:0] ma, mb, uq, ur;
        neg_a = sgn && a[31];
        neg_b = sgn && b[31];
        ma    = neg_a ? -a : a;
        mb    = neg_b ? -b : b;
        uq    = (mb == 0) ? 32'hFFFF_FFFF : ma / mb;
        ur    = (mb == 0) ? ma : ma % mb;
        q     = (neg_a ^ neg_b) ? -uq : uq;
        r     = neg_a ? -ur : ur;
    endtask

    // Called at negedge+1 while the DUT is in IDLE; returns at negedge+1 in IDLE.
    task automatic run_div(input logic [31:0] a, input logic [31:0] b, input logic sgn,
                           input int hold, input logic [31:0] eq, input logic [31:0] er);
        int stall_cnt;
        int cycles;
        stall_cnt  = 0;
        cycles     = 0;
        div_en     = 1'b1;
        div_signed = sgn;
        src_a      = a;
        src_b      = b;
        #1;
        while (res_valid !== 1'b1 && cycles < 100) begin
            if (div_stall === 1'b1) stall_cnt++;
            pipe_hold = 1'($urandom_range(0, 1));
            @(negedge clk);
            #1;
            cycles++;
        end
        check("done_reached", {31'd0, res_valid}, 32'd1);
        check("stall_cycles", stall_cnt, 32'd33);
        check("stall_in_done", {31'd0, div_stall}, 32'd0);
        check("quotient", quotient, eq);
        check("remainder", remainder, er);
        for (int k = 0; k < hold; k++) begin
            pipe_hold = 1'b1;
            @(negedge clk);
            #1;
            check("hold_valid", {31'd0, res_valid}, 32'd1);
            check("hold_stall", {31'd0, div_stall}, 32'd0);
            check("hold_quotient", quotient, eq);
            check("hold_remainder", remainder, er);
        end
        pipe_hold = 1'b0;
        div_en    = 1'b0;
        @(negedge clk);
        #1;
        check("idle_valid", {31'd0, res_valid}, 32'd0);
        check("idle_stall", {31'd0, div_stall}, 32'd0);
    endtask

    initial begin
        logic [31:0] ra, rb, rq, rr;
        logic        rs;
        errors     = 0;
        checks     = 0;
        resetn     = 1'b0;
        div_en     = 1'b1;
        div_signed = 1'b0;
        src_a      = 32'd100;
        src_b      = 32'd7;
        flush      = 1'b0;
        pipe_hold  = 1'b0;

        #2;
        check("rst_stall", {31'd0, div_stall}, 32'd0);
        check("rst_valid", {31'd0, res_valid}, 32'd0);
        check("rst_quotient", quotient, 32'd0);
        check("rst_remainder", remainder, 32'd0);
        @(negedge clk);
        resetn = 1'b1;
        div_en = 1'b0;
        #1;

        run_div(32'd100, 32'd7, 1'b0, 0, 32'd14, 32'd2);
        run_div(32'hFFFF_FFF9, 32'd2, 1'b1, 0, 32'hFFFF_FFFD, 32'hFFFF_FFFF);
        run_div(32'd7, 32'hFFFF_FFFE, 1'b1, 0, 32'hFFFF_FFFD, 32'd1);
        run_div(32'h8000_0000, 32'hFFFF_FFFF, 1'b1, 0, 32'h8000_0000, 32'd0);
        run_div(32'd5, 32'd0, 1'b0, 0, 32'hFFFF_FFFF, 32'd5);

        // Flush on the 10th CALC cycle.
        div_en     = 1'b1;
        div_signed = 1'b0;
        src_a      = 32'd1000;
        src_b      = 32'd3;
        #1;
        check("flush_start_stall", {31'd0, div_stall}, 32'd1);
        repeat (10) @(negedge clk);
        #1;
        check("flush_pre_stall", {31'd0, div_stall}, 32'd1);
        flush = 1'b1;
        #1;
        check("flush_stall_drop", {31'd0, div_stall}, 32'd0);
        @(negedge clk);
        flush  = 1'b0;
        div_en = 1'b0;
        #1;
        for (int k = 0; k < 3; k++) begin
            check("flush_no_valid", {31'd0, res_valid}, 32'd0);
            check("flush_idle_stall", {31'd0, div_stall}, 32'd0);
            @(negedge clk);
            #1;
        end
        run_div(32'd9, 32'd3, 1'b0, 0, 32'd3, 32'd0);

        // Held in DONE for 3 cycles with div_en still high.
        run_div(32'd50000, 32'd123, 1'b0, 3, 32'd406, 32'd62);

        // Async reset on the 15th CALC cycle.
        div_en     = 1'b1;
        div_signed = 1'b0;
        src_a      = 32'd77;
        src_b      = 32'd5;
        repeat (15) @(negedge clk);
        #1;
        check("prerst_stall", {31'd0, div_stall}, 32'd1);
        check("prerst_quotient", quotient, 32'd406);
        resetn = 1'b0;
        #1;
        check("midrst_stall", {31'd0, div_stall}, 32'd0);
        check("midrst_valid", {31'd0, res_valid}, 32'd0);
        check("midrst_quotient", quotient, 32'd0);
        check("midrst_remainder", remainder, 32'd0);
        @(negedge clk);
        resetn = 1'b1;
        #1;
        run_div(32'd77, 32'd5, 1'b0, 0, 32'd15, 32'd2);

        for (int i = 0; i < 16; i++) begin
            ra = $urandom;
            case ($urandom_range(0, 3))
                0:       rb = 32'd0;
                1:       rb = 32'($urandom_range(1, 15));
                2:       rb = -32'($urandom_range(1, 15));
                default: rb = $urandom;
            endcase
            rs = 1'($urandom_range(0, 1));
            model(ra, rb, rs, rq, rr);
            run_div(ra, rb, rs, $urandom_range(0, 2), rq, rr);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/div_ctrl.md
Name: div_ctrl

Overview:
Multi-cycle integer divider and sequencer for the EX stage. It executes MIPS DIV/DIVU with a radix-2 restoring algorithm, one quotient bit per cycle. It drives div_stall to the pipeline control unit, which freezes IF/ID/EX and bubbles EX/WB while a divide runs. Results go to the HI/LO write path through quotient/remainder with res_valid.

Parameters:
WIDTH, 32, operand/result width in bits.
CNT_W, 6, iteration counter width; must satisfy 2^CNT_W > WIDTH.

Ports:
clk  input  1  clock, all state updates on rising edge
resetn  input  1  asynchronous active-low reset
div_en  input  1  EX stage holds a valid DIV/DIVU
div_signed  input  1  1 = DIV (signed), 0 = DIVU
src_a  input  WIDTH  dividend (rs)
src_b  input  WIDTH  divisor (rt)
flush  input  1  exception/eret flush of EX; cancels the operation
pipe_hold  input  1  EX held by a downstream stall (data-side wait)
div_stall  output  1  hold IF/ID/EX, bubble EX/WB
res_valid  output  1  quotient/remainder valid for the instruction in EX
quotient  output  WIDTH  LO result
remainder  output  WIDTH  HI result

Behaviour:
- Reset (async, resetn=0): state=IDLE, counter=0, internal registers=0, quotient=0, remainder=0, res_valid=0. div_stall=0 regardless of inputs.
- States: IDLE, CALC, DONE.
- IDLE, start condition div_en && !flush:
  - Latch |src_a| and |src_b|. Absolute values are used only when div_signed=1; otherwise operands are taken as unsigned.
  - Latch sign_q = a[W-1]^b[W-1] and sign_r = a[W-1], both gated by div_signed.
  - Clear the partial remainder and counter, then go to CALC.
- CALC, each cycle:
  - Shift {rem, dvd} left 1.
  - trial = rem_shifted − divisor, computed at WIDTH+1 bits.
  - If trial is non-negative, rem=trial and the new quotient LSB is 1; otherwise rem is unchanged and the LSB is 0.
  - counter++. After the WIDTH-th iteration (counter==WIDTH−1), go to DONE.
- Entering DONE:
  - quotient = sign_q ? −q : q and remainder = sign_r ? −r : r, both two's complement mod 2^WIDTH.
  - Registered outputs, stable for the whole DONE residency.
- DONE: res_valid=1.
  - Stay in DONE while pipe_hold=1. Never restart from DONE even though div_en is still high.
  - Go to IDLE when pipe_hold=0.
- div_stall is combinational: (IDLE && div_en && !flush) || (CALC && !flush). It is 0 in DONE.
- Latency: start accepted at cycle T, CALC runs T+1..T+WIDTH, DONE at T+WIDTH+1. div_stall is high for exactly WIDTH+1 cycles (33).
- flush in CALC or DONE: go to IDLE next edge. div_stall drops in the same cycle. res_valid goes to 0 next cycle. quotient/remainder keep their old values but are not valid.
- flush && div_en in IDLE: no start.
- pipe_hold in IDLE or CALC has no effect. The divider keeps iterating; EX is frozen anyway.
- Divide by zero is architecturally undefined, but the result is fixed for verification: unsigned gives q=all-ones, r=src_a. Signed gives the same computed on magnitudes, then the sign fix-up.
- Signed overflow: 0x80000000 / −1 gives q=0x80000000, r=0.
- Back-to-back divides: the second start is seen in IDLE the cycle after DONE exits, so one gap cycle with div_stall=0 is required.

Test Plan:
- DIVU 100/7 → div_stall high exactly 33 cycles, then res_valid=1 for 1 cycle with q=14, r=2; state returns to IDLE.
- DIV −7/2 (0xFFFFFFF9, 2) → q=0xFFFFFFFD, r=0xFFFFFFFF. DIV 7/−2 → q=0xFFFFFFFD, r=1.
- DIV 0x80000000 / 0xFFFFFFFF → q=0x80000000, r=0. DIVU 5/0 → q=0xFFFFFFFF, r=5.
- flush asserted on the 10th CALC cycle → div_stall 0 in that cycle, IDLE next edge, no res_valid. A new DIVU 9/3 afterwards → q=3, r=0 after 33 stall cycles.
- pipe_hold=1 for 3 cycles on entering DONE → res_valid and results stable for 4 cycles, div_stall stays 0, no restart. Release → IDLE.
- resetn pulsed low mid-CALC (cycle 15) → all outputs 0 immediately (async). After release with div_en=1, a fresh 33-cycle divide starts.
